// File: rtl/led_blink_controller.sv
// Command-driven two-channel LED sequencer: OFF, ON, continuous BLINK or counted BURST,
// all paced by a shared free-running tick prescaler.
module led_blink_controller #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 10,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_LED,
    input  logic [1:0]       CMD_MODE,
    input  logic [CNT_W-1:0] CMD_HALF,
    input  logic [CNT_W-1:0] CMD_REPS,
    output logic             DONE,
    output logic             LED1,
    output logic             LED2
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ON      = 3'd1,
        ST_BLINK_H = 3'd2,
        ST_BLINK_L = 3'd3,
        ST_BURST_H = 3'd4,
        ST_BURST_L = 3'd5
    } chan_state_e;

    typedef struct packed {
        chan_state_e      state;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] reps;
        logic [CNT_W-1:0] phase;
    } chan_t;

    localparam chan_t CHAN_RESET = '{state: ST_OFF, half: CNT_W'(1), reps: CNT_W'(0), phase: CNT_W'(0)};

    // Static channels hold their phase so that no per-channel counter ever wraps.
    function automatic logic is_timed(input chan_state_e s);
        logic r;
        case (s)
            ST_BLINK_H, ST_BLINK_L, ST_BURST_H, ST_BURST_L: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_burst(input chan_state_e s);
        logic r;
        case (s)
            ST_BURST_H, ST_BURST_L: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic led_of(input chan_state_e s);
        logic r;
        case (s)
            ST_ON, ST_BLINK_H, ST_BURST_H: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic chan_t chan_next(
        input  chan_t            cur,
        input  logic             tick,
        input  logic             load,
        input  logic [1:0]       mode,
        input  logic [CNT_W-1:0] half,
        input  logic [CNT_W-1:0] reps,
        output logic             done
    );
        chan_t nxt;
        nxt  = cur;
        done = 1'b0;
        if (load) begin
            nxt.phase = CNT_ZERO;
            nxt.half  = (half == CNT_ZERO) ? CNT_ONE : half;
            nxt.reps  = reps;
            case (mode)
                MODE_OFF:   nxt.state = ST_OFF;
                MODE_ON:    nxt.state = ST_ON;
                MODE_BLINK: nxt.state = ST_BLINK_H;
                MODE_BURST: begin
                    // A zero-length burst completes on the accepting edge.
                    if (reps == CNT_ZERO) begin
                        nxt.state = ST_OFF;
                        done      = 1'b1;
                    end else begin
                        nxt.state = ST_BURST_H;
                    end
                end
                default:    nxt.state = ST_OFF;
            endcase
        end else if (tick && is_timed(cur.state)) begin
            if (cur.phase == (cur.half - CNT_ONE)) begin
                nxt.phase = CNT_ZERO;
                case (cur.state)
                    ST_BLINK_H: nxt.state = ST_BLINK_L;
                    ST_BLINK_L: nxt.state = ST_BLINK_H;
                    ST_BURST_H: nxt.state = ST_BURST_L;
                    ST_BURST_L: begin
                        if (cur.reps > CNT_ONE) begin
                            nxt.state = ST_BURST_H;
                            nxt.reps  = cur.reps - CNT_ONE;
                        end else begin
                            nxt.state = ST_OFF;
                            done      = 1'b1;
                        end
                    end
                    default:    nxt.state = cur.state;
                endcase
            end else begin
                nxt.phase = cur.phase + CNT_ONE;
            end
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    chan_t              chan_q [2];
    chan_t              chan_d [2];
    logic [1:0]         led_q;
    logic [1:0]         led_d;
    logic               done_q;
    logic               done_d;
    logic [1:0]         done_ch_s;
    logic               tick_s;
    logic               accept_s;
    logic               cmd_ready_s;

    assign tick_s      = (presc_q == PRESC_MAX);
    assign cmd_ready_s = !(is_burst(chan_q[0].state) || is_burst(chan_q[1].state));
    assign accept_s    = CMD_VALID && cmd_ready_s;

    // Next-state for prescaler, both channels and the registered outputs.
    always_comb begin
        presc_d   = tick_s ? PRESC_ZERO : (presc_q + PRESC_ONE);
        done_ch_s = 2'b00;
        chan_d[0] = chan_next(chan_q[0], tick_s, accept_s && (CMD_LED == 1'b0),
                              CMD_MODE, CMD_HALF, CMD_REPS, done_ch_s[0]);
        chan_d[1] = chan_next(chan_q[1], tick_s, accept_s && (CMD_LED == 1'b1),
                              CMD_MODE, CMD_HALF, CMD_REPS, done_ch_s[1]);
        done_d    = |done_ch_s;
        led_d[0]  = led_of(chan_d[0].state);
        led_d[1]  = led_of(chan_d[1].state);
    end

    // State register; reset clears everything, so an aborted burst never reports DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q   <= PRESC_ZERO;
            chan_q[0] <= CHAN_RESET;
            chan_q[1] <= CHAN_RESET;
            led_q     <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            chan_q[0] <= chan_d[0];
            chan_q[1] <= chan_d[1];
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    assign CMD_READY = cmd_ready_s;
    assign DONE      = done_q;
    assign LED1      = led_q[0];
    assign LED2      = led_q[1];

endmodule

// File: tb/tb_led_blink_controller.sv
// Directed bench for led_blink_controller with CLK_HZ=100, TICK_HZ=10 (10 clocks per tick).
module tb_led_blink_controller;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_LED;
    logic [1:0] CMD_MODE;
    logic [7:0] CMD_HALF;
    logic [7:0] CMD_REPS;
    logic       DONE;
    logic       LED1;
    logic       LED2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic       led;
        logic [1:0] mode;
        logic [7:0] half;
        logic [7:0] reps;
        logic       e_led1;
        logic       e_led2;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t vecs [9];

    led_blink_controller #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_LED(CMD_LED), .CMD_MODE(CMD_MODE), .CMD_HALF(CMD_HALF), .CMD_REPS(CMD_REPS),
        .DONE(DONE), .LED1(LED1), .LED2(LED2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic led, input logic [1:0] mode,
                         input logic [7:0] half, input logic [7:0] reps);
        CMD_VALID = v;
        CMD_LED   = led;
        CMD_MODE  = mode;
        CMD_HALF  = half;
        CMD_REPS  = reps;
    endtask

    // Counts edges until the selected LED leaves value 'from'; bounded by 'max'.
    task automatic wait_led(input int idx, input logic from, input int max, output int n);
        logic cur;
        n = 0;
        do begin
            step();
            n++;
            cur = (idx == 0) ? LED1 : LED2;
        end while (cur === from && n < max);
        if (cur === from) begin
            checks++;
            errors++;
            $display("FAIL wait_led%0d: still %0d after %0d cycles", idx + 1, from, n);
        end
    endtask

    initial begin
        int  n;
        bit  seen_done;

        vecs[0] = '{1'b1, 1'b0, M_ON,    8'd0,   8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, M_ON,    8'd0,   8'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, M_OFF,   8'd0,   8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, M_BURST, 8'd3,   8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, M_OFF,   8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, M_BLINK, 8'd200, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, M_ON,    8'd0,   8'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, M_OFF,   8'd0,   8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, M_OFF,   8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        RST = 1'b1;
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        repeat (3) step();
        check("rst_led1", LED1, 0);
        check("rst_led2", LED2, 0);
        check("rst_done", DONE, 0);
        RST = 1'b0;
        #1;
        check("rst_ready", CMD_READY, 1);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].led, vecs[i].mode, vecs[i].half, vecs[i].reps);
            step();
            check($sformatf("vec%0d_led1", i), LED1, vecs[i].e_led1);
            check($sformatf("vec%0d_led2", i), LED2, vecs[i].e_led2);
            check($sformatf("vec%0d_done", i), DONE, vecs[i].e_done);
            check($sformatf("vec%0d_ready", i), CMD_READY, vecs[i].e_ready);
        end
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);

        // Reset during an active blink, then prove the prescaler restarts from zero.
        drive(1'b1, 1'b0, M_BLINK, 8'd1, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        repeat (5) step();
        RST = 1'b1;
        #1;
        check("rstblink_led1", LED1, 0);
        check("rstblink_led2", LED2, 0);
        check("rstblink_done", DONE, 0);
        repeat (3) step();
        RST = 1'b0;
        drive(1'b1, 1'b0, M_BLINK, 8'd1, 8'd0);
        #1;
        check("rstblink_ready", CMD_READY, 1);
        step();
        check("presc_led1_on", LED1, 1);
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        wait_led(0, 1'b1, 20, n);
        check("presc_first_tick", n, 9);
        wait_led(0, 1'b0, 20, n);
        check("presc_half", n, 10);
        drive(1'b1, 1'b0, M_OFF, 8'd0, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        check("presc_off", LED1, 0);

        // LED2 blink, half=3.
        drive(1'b1, 1'b1, M_BLINK, 8'd3, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        check("blink3_start", LED2, 1);
        wait_led(1, 1'b1, 40, n);
        check_range("blink3_first", n, 21, 30);
        for (int t = 0; t < 6; t++) begin
            wait_led(1, LED2, 40, n);
            check($sformatf("blink3_toggle%0d", t), n, 30);
        end
        check("blink3_led1", LED1, 0);
        drive(1'b1, 1'b1, M_OFF, 8'd0, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);

        // LED1 burst half=1 reps=2 with a competing command held throughout.
        drive(1'b1, 1'b0, M_BURST, 8'd1, 8'd2);
        step();
        check("burst_led1_h", LED1, 1);
        check("burst_ready0", CMD_READY, 0);
        drive(1'b1, 1'b1, M_ON, 8'd0, 8'd0);
        wait_led(0, 1'b1, 20, n);
        check_range("burst_h1", n, 1, 10);
        check("burst_ready1", CMD_READY, 0);
        wait_led(0, 1'b0, 20, n);
        check("burst_l1", n, 10);
        wait_led(0, 1'b1, 20, n);
        check("burst_h2", n, 10);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("burst_end_done%0d", k), DONE, (k == 10) ? 1 : 0);
            check($sformatf("burst_end_ready%0d", k), CMD_READY, (k == 10) ? 1 : 0);
            check($sformatf("burst_end_led2_%0d", k), LED2, 0);
        end
        check("burst_final_led1", LED1, 0);
        step();
        check("held_cmd_led2", LED2, 1);
        check("held_cmd_done", DONE, 0);
        drive(1'b1, 1'b1, M_OFF, 8'd0, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);

        // HALF=0 acts as HALF=1.
        drive(1'b1, 1'b0, M_BLINK, 8'd0, 8'd0);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        check("half0_start", LED1, 1);
        wait_led(0, 1'b1, 20, n);
        check_range("half0_first", n, 1, 10);
        wait_led(0, 1'b0, 20, n);
        check("half0_t1", n, 10);
        wait_led(0, 1'b1, 20, n);
        check("half0_t2", n, 10);
        drive(1'b1, 1'b0, M_OFF, 8'd0, 8'd0);
        step();

        // BURST with REPS=0.
        drive(1'b1, 1'b1, M_BURST, 8'd4, 8'd0);
        #1;
        check("reps0_ready_pre", CMD_READY, 1);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        check("reps0_done", DONE, 1);
        check("reps0_led2", LED2, 0);
        check("reps0_ready", CMD_READY, 1);
        step();
        check("reps0_done_clr", DONE, 0);

        // Reset in the middle of a burst: no DONE afterwards.
        drive(1'b1, 1'b1, M_BURST, 8'd2, 8'd5);
        step();
        drive(1'b0, 1'b0, M_OFF, 8'd0, 8'd0);
        check("abort_led2_on", LED2, 1);
        check("abort_ready0", CMD_READY, 0);
        repeat (15) step();
        #2;
        RST = 1'b1;
        #1;
        check("abort_led2", LED2, 0);
        check("abort_ready", CMD_READY, 1);
        check("abort_done", DONE, 0);
        repeat (2) step();
        RST = 1'b0;
        seen_done = 1'b0;
        repeat (150) begin
            step();
            if (DONE) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_ready_after", CMD_READY, 1);
        check("abort_led2_after", LED2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_controller.md
Name: led_blink_controller

Overview:
Command-driven sequencer for the two board LEDs (LED1, LED2) on the 100 MHz clock. It replaces hard-wired free-running blinkers with per-LED modes: OFF, ON, continuous BLINK, or counted BURST. A shared prescaler generates a slow tick. Commands arrive on a valid/ready handshake from a button or UART front end. BURST completion is reported with a one-cycle DONE pulse.

Parameters:
CLK_HZ, 100000000, input clock frequency
TICK_HZ, 10, tick rate; TICK_DIV = CLK_HZ/TICK_HZ clocks per tick, must be >= 2
CNT_W, 8, width of half-period and repetition fields

Ports:
CLK  input  1  system clock, 100 MHz
RST  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  controller can accept a command
CMD_LED  input  1  target: 0=LED1, 1=LED2
CMD_MODE  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
CMD_HALF  input  CNT_W  half-period in ticks (0 treated as 1)
CMD_REPS  input  CNT_W  BURST on/off cycle count
DONE  output  1  one-cycle pulse when a BURST completes
LED1  output  1  LED1 drive, registered
LED2  output  1  LED2 drive, registered

Behaviour:
- One clock domain. RST is asynchronous and active-high. While RST=1 and on release, all state clears:
  - LED1=0, LED2=0, DONE=0.
  - Prescaler=0, both channels in OFF.
  - CMD_READY=1 after release.
- Prescaler: counts 0..TICK_DIV-1 and wraps; TICK is high for the one cycle the count equals TICK_DIV-1. It is free-running and is never reset by commands.
- Accept: a command is accepted on an edge where CMD_VALID=1 and CMD_READY=1. The target LED output reflects the new mode at the next edge (1-cycle latency). The other channel is unaffected.
- CMD_READY is combinational and equals 1 when neither channel is in a BURST state. CMD_VALID held while CMD_READY=0 is ignored with no side effects.
- Per-channel state: OFF, ON, BLINK_H, BLINK_L, BURST_H, BURST_L.
  - Each channel latches half (min 1), a reps counter, and a phase counter on accept.
  - The phase counter clears on accept and increments on TICK.
  - A half-period ends on the TICK where phase == half-1; the phase counter then clears.
- Mode behaviour:
  - OFF: LED=0.
  - ON: LED=1.
  - BLINK: enters BLINK_H (LED=1) and alternates H/L at each half-period end, indefinitely.
  - BURST, REPS>0: enters BURST_H (LED=1).
    - BURST_H→BURST_L at each half-period end.
    - BURST_L→BURST_H at each half-period end while reps>1, with reps decremented.
    - When reps==1, BURST_L→OFF.
    - On the edge entering OFF, DONE=1 for exactly one cycle and CMD_READY returns to 1.
  - BURST, REPS=0: channel goes to OFF (LED=0) and DONE pulses on the next edge. CMD_READY never drops.
- Timing:
  - The first half-period after accept lasts (half-1)*TICK_DIV+1 to half*TICK_DIV clocks, because prescaler phase is not aligned to the command.
  - Subsequent half-periods are exactly half*TICK_DIV clocks.
- Override: a new command to a channel in OFF/ON/BLINK replaces its mode immediately and reloads its counters.
- Reset mid-operation: a BURST aborted by reset produces no DONE pulse.
- Counter widths:
  - Phase and reps counters are CNT_W bits.
  - The prescaler is ceil(log2(TICK_DIV)) bits.
  - No counter may wrap except the prescaler.

Test Plan (CLK_HZ=100, TICK_HZ=10 → TICK_DIV=10):
1. Assert RST for 3 cycles during an active BLINK on LED1 → LED1=0, LED2=0, DONE=0, CMD_READY=1 after release; prescaler restarts (first TICK 10 clocks after release).
2. Command LED=0 MODE=ON → LED1=1 one edge after accept, LED2 stays 0. Then MODE=OFF → LED1=0 one edge later.
3. Command LED=1 MODE=BLINK HALF=3 → LED2=1 next edge; first high interval 21–30 clocks; thereafter LED2 toggles every 30 clocks for at least 6 toggles; LED1 untouched.
4. Command LED=0 MODE=BURST HALF=1 REPS=2:
   - LED1 sequence is H,L,H,L, with every interval after the first exactly 10 clocks, then LED1=0.
   - DONE is a single-cycle pulse on the final transition edge.
   - CMD_READY=0 from accept until that edge.
   - A CMD_VALID held during the burst is not accepted and is accepted on the first cycle after READY returns.
5. MODE=BLINK HALF=0 → behaves as HALF=1 (10-clock toggles). MODE=BURST REPS=0 → LED off, DONE pulses one edge after accept, CMD_READY stays 1.
6. Start BURST HALF=2 REPS=5 on LED2 and assert RST mid-burst → LED2=0 immediately, DONE never pulses, CMD_READY=1 after release.
